uart_tx: RTL and testbench

- 8N1 UART emitter that consumes the rv32 core's UART write channel and drives the serial line out of the UART top level.
- Accepts a 9-bit optional byte {valid, data[7:0]} and returns a ready flag on the core's write feedback port.
- Buffers bytes in a small FIFO so back-to-back core writes do not stall for a full frame.
- Serialises each byte as 1 start bit, 8 data bits LSB first, and 1 stop bit.

---
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 UART transmitter fed by the core's UART write channel.
//            Incoming bytes go into a small circular FIFO, so back-to-back
//            core writes do not wait for a whole frame. Each byte is sent as
//            one start bit, eight data bits (LSB first) and one stop bit.
// Ports    : CLK          system clock, rising-edge active
//            RST_N        asynchronous active-low reset
//            wr_opt_byte  [8] valid, [7:0] byte to transmit
//            wr_ready     a byte can be accepted this cycle
//            line_out     serial TX line, idles high, registered
//            busy         a frame is on the line or the FIFO holds data
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_LOG2    = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [8:0] wr_opt_byte,
    output logic       wr_ready,
    output logic       line_out,
    output logic       busy
);

    localparam int c_DEPTH  = 1 << FIFO_LOG2;
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0]  c_BAUD_RELOAD = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_LOG2:0]   c_FULL_COUNT  = (FIFO_LOG2 + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state, w_state_next;
    logic [7:0]             r_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0]   r_wr_ptr, r_rd_ptr;
    logic [FIFO_LOG2:0]     r_count;
    logic [c_BAUD_W-1:0]    r_baud, w_baud_next;
    logic [2:0]             r_bit_idx, w_bit_idx_next;
    logic [7:0]             r_shreg, w_shreg_next;
    logic                   r_line, w_line_next;
    logic                   w_full, w_empty, w_push, w_pop;

    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_empty  = (r_count == '0);
    // Held low throughout reset so the core never sees a spurious accept.
    assign wr_ready = RST_N && !w_full;
    assign w_push   = wr_opt_byte[8] && wr_ready;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign line_out = r_line;

    // ------------------------------------------------------------------
    // FIFO storage (data only, no reset needed) and pointers/occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_opt_byte[7:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_line    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shreg   <= w_shreg_next;
            r_line    <= w_line_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state. The line level for the coming bit is decided
    // here and registered together with the state, so line_out changes on
    // the same edge as the state and never glitches.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shreg_next   = r_shreg;
        w_line_next    = r_line;
        w_pop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_line_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shreg_next = r_mem[r_rd_ptr];
                    w_baud_next  = c_BAUD_RELOAD;
                    w_state_next = S_START;
                    w_line_next  = 1'b0;
                end
            end

            S_START: begin
                if (r_baud == '0) begin
                    w_state_next   = S_DATA;
                    w_baud_next    = c_BAUD_RELOAD;
                    w_bit_idx_next = '0;
                    w_line_next    = r_shreg[0];
                end else begin
                    w_baud_next = r_baud - 1'b1;
                end
            end

            S_DATA: begin
                if (r_baud == '0) begin
                    w_shreg_next   = {1'b0, r_shreg[7:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    w_baud_next    = c_BAUD_RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_line_next  = 1'b1;
                    end else begin
                        // Bit 1 of the unshifted register is the next data bit.
                        w_line_next = r_shreg[1];
                    end
                end else begin
                    w_baud_next = r_baud - 1'b1;
                end
            end

            S_STOP: begin
                if (r_baud == '0) begin
                    if (!w_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        w_pop        = 1'b1;
                        w_shreg_next = r_mem[r_rd_ptr];
                        w_baud_next  = c_BAUD_RELOAD;
                        w_state_next = S_START;
                        w_line_next  = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_line_next  = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud - 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_line_next  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx. Directed stimulus pushes each
//            accepted byte into an expected queue; a line monitor captures
//            every frame cycle by cycle and compares it against the ideal
//            10-bit 8N1 waveform of the byte at the head of the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FLOG2 = 2;
    localparam int FRAME = 10 * CPB;

    logic       CLK         = 1'b0;
    logic       RST_N       = 1'b1;
    logic [8:0] wr_opt_byte = '0;
    logic       wr_ready;
    logic       line_out;
    logic       busy;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_LOG2    (FLOG2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .wr_opt_byte (wr_opt_byte),
        .wr_ready    (wr_ready),
        .line_out    (line_out),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    bit         contig = 1'b0;
    bit         first_in_group = 1'b0;
    int         idle_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Ideal line waveform, one entry per clock: start, d0..d7, stop.
    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
        logic [FRAME-1:0] f;
        int               i;
        f = '0;
        for (int k = 0; k < FRAME; k++) begin
            i = k / CPB;
            if (i == 0)      f[k] = 1'b0;
            else if (i == 9) f[k] = 1'b1;
            else             f[k] = b[i-1];
        end
        return f;
    endfunction

    // ---------------- monitor ----------------
    task automatic capture();
        logic [FRAME-1:0] s;
        logic             aborted;
        logic [7:0]       e;
        s       = '0;
        aborted = 1'b0;
        s[0]    = line_out;
        for (int k = 1; k < FRAME; k++) begin
            @(negedge CLK);
            if (!RST_N) aborted = 1'b1;
            s[k] = line_out;
        end
        if (aborted) return;
        if (contig && !first_in_group) chk("frame_gap", idle_cnt, 0);
        first_in_group = 1'b0;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_frame: got frame 0x%0h, want no frame", s);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("frame_%02h", e), s, frame_bits(e));
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N && line_out === 1'b0) begin
                capture();
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    // ---------------- driver helpers ----------------
    // Called just after a negedge; returns just after the next negedge
    // following acceptance, with valid still asserted.
    task automatic send(input logic [7:0] b, output int waited);
        waited      = 0;
        wr_opt_byte = {1'b1, b};
        while (!wr_ready && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (!wr_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: byte 0x%02h wr_ready=%b, want 1", b, wr_ready);
        end else begin
            exp_q.push_back(b);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        chk("drain_done", {63'd0, (exp_q.size() == 0 && !busy)}, 64'd1);
        repeat (2 * CPB) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        bit quiet;

        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_line",  line_out, 1);
        chk("rst_busy",  busy,     0);
        chk("rst_ready", wr_ready, 0);
        RST_N = 1'b1;
        #1;
        chk("ready_after_rst", wr_ready, 1);
        chk("busy_after_rst",  busy,     0);
        @(negedge CLK);

        // Single byte 0x55: start one edge after acceptance, busy for 40 cycles.
        send(8'h55, w);
        chk("t1_line_before_pop", line_out, 1);
        chk("t1_busy_queued",     busy,     1);
        wr_opt_byte = '0;
        @(negedge CLK);
        chk("t1_line_start", line_out, 0);
        repeat (FRAME - 1) @(negedge CLK);
        chk("t1_busy_last_cycle", busy, 1);
        @(negedge CLK);
        chk("t1_busy_fall", busy, 0);
        drain();

        // Burst 0x00..0x05: sixth byte held off, frames contiguous.
        contig         = 1'b1;
        first_in_group = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(8'(i), w);
            chk($sformatf("burst_wait_%0d", i), w, 0);
        end
        wr_opt_byte = {1'b1, 8'h05};
        chk("burst_ready_low",  wr_ready,    0);
        chk("burst_count_full", dut.r_count, 4);
        @(negedge CLK);
        chk("holdoff_count", dut.r_count, 4);
        chk("holdoff_ready", wr_ready,    0);
        send(8'h05, w);
        wr_opt_byte = '0;
        drain();
        contig = 1'b0;

        // Boundary bytes.
        send(8'h00, w);
        send(8'hFF, w);
        wr_opt_byte = '0;
        drain();

        // Reset in the middle of data bit 3 with two bytes still queued.
        send(8'h11, w);
        send(8'h22, w);
        send(8'h33, w);
        wr_opt_byte = '0;
        repeat (16) @(negedge CLK);
        chk("pre_rst_bit3",  line_out,    0);
        chk("pre_rst_count", dut.r_count, 2);
        #1 RST_N = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_line",  line_out, 1);
        chk("midrst_busy",  busy,     0);
        chk("midrst_ready", wr_ready, 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (line_out !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("post_rst_quiet", quiet, 1);
        send(8'hA5, w);
        wr_opt_byte = '0;
        drain();

        // Push on the STOP-pop edge, then 10 bytes through the depth-4 FIFO.
        send(8'h30, w);
        send(8'h31, w);
        send(8'h32, w);
        wr_opt_byte = '0;
        repeat (38) @(negedge CLK);
        chk("pp_count_before", dut.r_count, 2);
        send(8'h33, w);
        chk("pp_count_after", dut.r_count, 2);
        for (int i = 4; i < 10; i++) begin
            send(8'(8'h30 + i), w);
        end
        wr_opt_byte = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
